// File: rtl/store_pkg.sv
// store_pkg
// Shared definitions for the data-memory store sequencer:
//   - tam size codes as issued by the multicycle control unit
//   - the sequencer state enumeration
//   - byte-lane constants and the base lane mask for each store size
package store_pkg;

   localparam int DW    = 64;
   localparam int BYTES = DW / 8;

   localparam logic [1:0] TAM_SD = 2'b00;
   localparam logic [1:0] TAM_SW = 2'b01;
   localparam logic [1:0] TAM_SH = 2'b10;
   localparam logic [1:0] TAM_SB = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE,
      ST_FAULT
   } store_state_t;

   // Lanes covered by a store of the given size when it sits at byte offset 0.
   // Shifting this mask left by the byte offset gives the lanes to replace.
   function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] tam);
      logic [BYTES-1:0] m;
      case (tam)
         TAM_SD:  m = 8'hFF;
         TAM_SW:  m = 8'h0F;
         TAM_SH:  m = 8'h03;
         default: m = 8'h01;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge
// Combinational byte-lane merge for partial stores into a 64-bit doubleword.
// Ports:
//   rd      in  64  current doubleword contents (read-back data)
//   wd      in  64  store data, right-justified
//   tam     in  2   store size code (sd/sw/sh/sb)
//   offset  in  3   byte offset of the store inside the doubleword
//   merged  out 64  rd with the addressed lanes replaced by wd (little-endian)
//   aligned out 1   high when offset is naturally aligned for the size
module store_merge
   import store_pkg::*;
(
   input  logic [DW-1:0] rd,
   input  logic [DW-1:0] wd,
   input  logic [1:0]    tam,
   input  logic [2:0]    offset,
   output logic [DW-1:0] merged,
   output logic          aligned
);

   logic [BYTES-1:0] lanes;
   logic [DW-1:0]    wd_shift;

   // Move the store data up to its byte offset and pick the lanes it covers.
   // Data bits above the store size end up in unselected lanes (or shift out),
   // so they are discarded by the lane mask without any explicit truncation.
   always_comb begin
      lanes    = lane_mask(tam) << offset;
      wd_shift = wd << {offset, 3'b000};
      merged   = rd;
      for (int i = 0; i < BYTES; i++) begin
         if (lanes[i]) begin
            merged[8*i +: 8] = wd_shift[8*i +: 8];
         end
      end
   end

   // Natural alignment: the low address bits covered by the size must be zero.
   always_comb begin
      case (tam)
         TAM_SD:  aligned = (offset == 3'b000);
         TAM_SW:  aligned = (offset[1:0] == 2'b00);
         TAM_SH:  aligned = (offset[0] == 1'b0);
         default: aligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// store_unit
// Data-memory write sequencer. Full doubleword stores are written directly;
// word/half/byte stores read the enclosing doubleword, merge the new lanes and
// write it back, so the memory only ever sees whole-doubleword writes.
// Ports:
//   clk        in  1       clock, rising edge
//   reset_n    in  1       synchronous active-low reset
//   start      in  1       store request, only honoured in IDLE
//   tam        in  2       size: 00 sd, 01 sw, 10 sh, 11 sb
//   addr       in  ADDR_W  byte address
//   wdata      in  DATA_W  right-justified store data
//   mem_addr   out ADDR_W  doubleword-aligned memory address
//   mem_rdata  in  DATA_W  read data, valid MEM_RD_LAT cycles after mem_addr
//   mem_wdata  out DATA_W  merged write data
//   mem_we     out 1       one-cycle write strobe
//   busy       out 1       high whenever not IDLE
//   done       out 1       one-cycle completion pulse
//   misalign   out 1       one-cycle pulse, unaligned request rejected
module store_unit
   import store_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 64,
   parameter int MEM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        tam,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              misalign
);

   localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

   store_state_t      state;
   logic [1:0]        tam_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;

   logic [1:0]        sel_tam;
   logic [2:0]        sel_off;
   logic [DATA_W-1:0] sel_wd;
   logic [DATA_W-1:0] merged;
   logic              aligned;

   // The memory address is a pure function of the latched address, so it
   // holds from the accepting edge onwards and only clears on reset.
   assign mem_addr = {addr_q[ADDR_W-1:3], 3'b000};

   // The single merge unit serves two purposes: in IDLE it judges alignment
   // (and builds the sd write word) from the live request, afterwards it works
   // on the latched operands so later input changes have no effect.
   always_comb begin
      sel_tam = tam_q;
      sel_off = addr_q[2:0];
      sel_wd  = wdata_q;
      if (state == ST_IDLE) begin
         sel_tam = tam;
         sel_off = addr[2:0];
         sel_wd  = wdata;
      end
   end

   // The merge always sees mem_rdata as the base doubleword. It only matters
   // on the READ->WRITE edge, where read data is captured straight into the
   // registered write word; for sd every lane is replaced so rd is irrelevant.
   store_merge u_merge (
      .rd      (mem_rdata),
      .wd      (sel_wd),
      .tam     (sel_tam),
      .offset  (sel_off),
      .merged  (merged),
      .aligned (aligned)
   );

   // Sequencer FSM with registered outputs. Strobes (mem_we, done, misalign)
   // default low each cycle and are raised only on the edge entering the state
   // they belong to, which makes each of them exactly one cycle wide.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         tam_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         mem_we   <= 1'b0;
         done     <= 1'b0;
         misalign <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  tam_q   <= tam;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  busy    <= 1'b1;
                  if (!aligned) begin
                     state    <= ST_FAULT;
                     misalign <= 1'b1;
                  end else if (tam == TAM_SD) begin
                     state     <= ST_WRITE;
                     mem_we    <= 1'b1;
                     mem_wdata <= merged;
                  end else begin
                     state <= ST_READ;
                     cnt   <= CNT_W'(MEM_RD_LAT - 1);
                  end
               end
            end
            ST_READ: begin
               if (cnt == '0) begin
                  state     <= ST_WRITE;
                  mem_we    <= 1'b1;
                  mem_wdata <= merged;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WRITE: begin
               state <= ST_DONE;
               done  <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            ST_FAULT: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit
// Directed bench for store_unit. Two instances share the clock: dut_a with a
// one-cycle memory read latency and dut_b with three cycles. Expected writes
// are queued when a request is driven and checked when mem_we appears.
module tb_store_unit;
   import store_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut_a signals (MEM_RD_LAT = 1)
   logic        a_reset_n, a_start, a_mem_we, a_busy, a_done, a_misalign;
   logic [1:0]  a_tam;
   logic [63:0] a_addr, a_wdata, a_mem_addr, a_mem_rdata, a_mem_wdata;

   // dut_b signals (MEM_RD_LAT = 3)
   logic        b_reset_n, b_start, b_mem_we, b_busy, b_done, b_misalign;
   logic [1:0]  b_tam;
   logic [63:0] b_addr, b_wdata, b_mem_addr, b_mem_rdata, b_mem_wdata;

   store_unit #(.DATA_W(64), .ADDR_W(64), .MEM_RD_LAT(1)) dut_a (
      .clk(clk), .reset_n(a_reset_n), .start(a_start), .tam(a_tam),
      .addr(a_addr), .wdata(a_wdata), .mem_addr(a_mem_addr),
      .mem_rdata(a_mem_rdata), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
      .busy(a_busy), .done(a_done), .misalign(a_misalign)
   );

   store_unit #(.DATA_W(64), .ADDR_W(64), .MEM_RD_LAT(3)) dut_b (
      .clk(clk), .reset_n(b_reset_n), .start(b_start), .tam(b_tam),
      .addr(b_addr), .wdata(b_wdata), .mem_addr(b_mem_addr),
      .mem_rdata(b_mem_rdata), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
      .busy(b_busy), .done(b_done), .misalign(b_misalign)
   );

   // Read-only memory images, preloaded by the stimulus block.
   logic [63:0] mem_a [0:15];
   logic [63:0] mem_b [0:15];
   logic [63:0] b_pipe0, b_pipe1;

   // dut_a memory answers within the cycle the address is presented.
   assign a_mem_rdata = mem_a[a_mem_addr[6:3]];

   // dut_b memory: two register stages, data ready by the third edge.
   always @(posedge clk) begin
      b_pipe0 <= mem_b[b_mem_addr[6:3]];
      b_pipe1 <= b_pipe0;
   end
   assign b_mem_rdata = b_pipe1;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t q_a[$];
   wr_t q_b[$];
   wr_t exp_a, exp_b;
   int  writes_a = 0;
   int  writes_b = 0;
   int  errors   = 0;
   int  checks   = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit to_b, input logic [1:0] t,
                                input logic [63:0] ad, input logic [63:0] wd,
                                input bit expect_wr, input logic [63:0] exp_addr,
                                input logic [63:0] exp_data);
      wr_t w;
      w.addr = exp_addr;
      w.data = exp_data;
      if (!to_b) begin
         a_tam = t; a_addr = ad; a_wdata = wd; a_start = 1'b1;
         if (expect_wr) q_a.push_back(w);
      end else begin
         b_tam = t; b_addr = ad; b_wdata = wd; b_start = 1'b1;
         if (expect_wr) q_b.push_back(w);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (a_mem_we === 1'b1) begin
         writes_a++;
         if (q_a.size() == 0) begin
            checkOutput("a_unexpected_we", 64'd1, 64'd0);
         end else begin
            exp_a = q_a.pop_front();
            checkOutput("a_wr_addr", a_mem_addr, exp_a.addr);
            checkOutput("a_wr_data", a_mem_wdata, exp_a.data);
         end
      end
      if (b_mem_we === 1'b1) begin
         writes_b++;
         if (q_b.size() == 0) begin
            checkOutput("b_unexpected_we", 64'd1, 64'd0);
         end else begin
            exp_b = q_b.pop_front();
            checkOutput("b_wr_addr", b_mem_addr, exp_b.addr);
            checkOutput("b_wr_data", b_mem_wdata, exp_b.data);
         end
      end
   end

   logic [1:0]  mis_tam  [0:2];
   logic [63:0] mis_addr [0:2];
   int          wcount;

   initial begin
      a_reset_n = 1'b0; a_start = 1'b0; a_tam = 2'b00; a_addr = '0; a_wdata = '0;
      b_reset_n = 1'b0; b_start = 1'b0; b_tam = 2'b00; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 64'h0;
         mem_b[i] = 64'h0;
      end
      mem_a[4] = 64'hFFFF_FFFF_FFFF_FFFF;
      mem_a[8] = 64'h0011_2233_4455_6677;
      mem_b[6] = 64'hAAAA_AAAA_AAAA_AAAA;
      mis_tam[0] = TAM_SH; mis_addr[0] = 64'h31;
      mis_tam[1] = TAM_SW; mis_addr[1] = 64'h02;
      mis_tam[2] = TAM_SD; mis_addr[2] = 64'h04;

      $display("[TB] reset");
      tick();
      tick();
      checkOutput("rst_busy", {63'd0, a_busy}, 64'd0);
      checkOutput("rst_done", {63'd0, a_done}, 64'd0);
      checkOutput("rst_misalign", {63'd0, a_misalign}, 64'd0);
      checkOutput("rst_we", {63'd0, a_mem_we}, 64'd0);
      checkOutput("rst_addr", a_mem_addr, 64'd0);
      checkOutput("rst_wdata", a_mem_wdata, 64'd0);
      checkOutput("rst_b_busy", {63'd0, b_busy}, 64'd0);
      a_reset_n = 1'b1;
      b_reset_n = 1'b1;
      tick();

      // sd: direct write, no read phase
      $display("[TB] sd direct write");
      applyStimulus(0, TAM_SD, 64'h10, 64'h1122_3344_5566_7788, 1, 64'h10, 64'h1122_3344_5566_7788);
      tick();
      a_start = 1'b0; a_tam = TAM_SB; a_addr = 64'hFF8; a_wdata = '1;
      checkOutput("sd_c1_we", {63'd0, a_mem_we}, 64'd1);
      checkOutput("sd_c1_addr", a_mem_addr, 64'h10);
      checkOutput("sd_c1_wdata", a_mem_wdata, 64'h1122_3344_5566_7788);
      checkOutput("sd_c1_done", {63'd0, a_done}, 64'd0);
      checkOutput("sd_c1_busy", {63'd0, a_busy}, 64'd1);
      tick();
      checkOutput("sd_c2_done", {63'd0, a_done}, 64'd1);
      checkOutput("sd_c2_we", {63'd0, a_mem_we}, 64'd0);
      checkOutput("sd_c2_addr", a_mem_addr, 64'h10);
      tick();
      checkOutput("sd_c3_done", {63'd0, a_done}, 64'd0);
      checkOutput("sd_c3_busy", {63'd0, a_busy}, 64'd0);

      // sb into an all-ones doubleword
      $display("[TB] sb read-modify-write");
      applyStimulus(0, TAM_SB, 64'h23, 64'hAB, 1, 64'h20, 64'hFFFF_FFFF_ABFF_FFFF);
      tick();
      a_start = 1'b0;
      checkOutput("sb_c1_we", {63'd0, a_mem_we}, 64'd0);
      checkOutput("sb_c1_busy", {63'd0, a_busy}, 64'd1);
      tick();
      checkOutput("sb_c2_we", {63'd0, a_mem_we}, 64'd1);
      checkOutput("sb_c2_wdata", a_mem_wdata, 64'hFFFF_FFFF_ABFF_FFFF);
      tick();
      checkOutput("sb_c3_done", {63'd0, a_done}, 64'd1);
      tick();
      checkOutput("sb_c4_busy", {63'd0, a_busy}, 64'd0);

      // sw into a zero doubleword, upper data bits must be ignored
      $display("[TB] sw read-modify-write, latency 1 and 3");
      applyStimulus(0, TAM_SW, 64'h2C, 64'h1234_5678_DEAD_BEEF, 1, 64'h28, 64'hDEAD_BEEF_0000_0000);
      applyStimulus(1, TAM_SW, 64'h2C, 64'h1234_5678_DEAD_BEEF, 1, 64'h28, 64'hDEAD_BEEF_0000_0000);
      tick();
      a_start = 1'b0;
      b_start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) tick();
         checkOutput("sw_a_done", {63'd0, a_done}, (c == 3) ? 64'd1 : 64'd0);
         checkOutput("sw_b_we", {63'd0, b_mem_we}, (c == 4) ? 64'd1 : 64'd0);
         checkOutput("sw_b_done", {63'd0, b_done}, (c == 5) ? 64'd1 : 64'd0);
      end
      tick();
      checkOutput("sw_b_idle", {63'd0, b_busy}, 64'd0);

      // misaligned requests are rejected without any write
      $display("[TB] misaligned requests");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, mis_tam[k], mis_addr[k], 64'h5555, 0, 64'd0, 64'd0);
         tick();
         a_start = 1'b0;
         checkOutput("mis_pulse", {63'd0, a_misalign}, 64'd1);
         checkOutput("mis_we", {63'd0, a_mem_we}, 64'd0);
         checkOutput("mis_busy", {63'd0, a_busy}, 64'd1);
         tick();
         checkOutput("mis_pulse_end", {63'd0, a_misalign}, 64'd0);
         checkOutput("mis_idle", {63'd0, a_busy}, 64'd0);
      end

      // start held high: one write per accepted request, re-accept from IDLE
      $display("[TB] start held high");
      wcount = writes_a;
      applyStimulus(0, TAM_SB, 64'h41, 64'hFFFF_FF5A, 1, 64'h40, 64'h0011_2233_4455_5A77);
      tick();
      checkOutput("held_c1_we", {63'd0, a_mem_we}, 64'd0);
      tick();
      checkOutput("held_c2_we", {63'd0, a_mem_we}, 64'd1);
      tick();
      checkOutput("held_c3_done", {63'd0, a_done}, 64'd1);
      tick();
      checkOutput("held_c4_busy", {63'd0, a_busy}, 64'd0);
      checkOutput("held_c4_done", {63'd0, a_done}, 64'd0);
      applyStimulus(0, TAM_SB, 64'h41, 64'hFFFF_FF5A, 1, 64'h40, 64'h0011_2233_4455_5A77);
      tick();
      a_start = 1'b0;
      checkOutput("held_c5_busy", {63'd0, a_busy}, 64'd1);
      tick();
      checkOutput("held_c6_we", {63'd0, a_mem_we}, 64'd1);
      tick();
      checkOutput("held_c7_done", {63'd0, a_done}, 64'd1);
      tick();
      checkOutput("held_writes", 64'(writes_a - wcount), 64'd2);

      // reset in the middle of a read phase aborts cleanly
      $display("[TB] reset during read");
      applyStimulus(1, TAM_SH, 64'h36, 64'hBEEF, 0, 64'd0, 64'd0);
      tick();
      b_start = 1'b0;
      checkOutput("rr_busy", {63'd0, b_busy}, 64'd1);
      b_reset_n = 1'b0;
      tick();
      b_reset_n = 1'b1;
      checkOutput("rr_busy0", {63'd0, b_busy}, 64'd0);
      checkOutput("rr_done0", {63'd0, b_done}, 64'd0);
      checkOutput("rr_mis0", {63'd0, b_misalign}, 64'd0);
      checkOutput("rr_we0", {63'd0, b_mem_we}, 64'd0);
      checkOutput("rr_addr0", b_mem_addr, 64'd0);
      checkOutput("rr_wdata0", b_mem_wdata, 64'd0);
      wcount = writes_b;
      repeat (6) tick();
      checkOutput("rr_no_write", 64'(writes_b - wcount), 64'd0);
      checkOutput("rr_idle", {63'd0, b_busy}, 64'd0);

      checkOutput("q_a_drained", 64'(q_a.size()), 64'd0);
      checkOutput("q_b_drained", 64'(q_b.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
